seq_cascade_comparator: RTL and testbench

- Multi-cycle magnitude comparator for wide unsigned operands. Processes one SLICE_W-bit slice per clock, LSB slice first.
- Drives the equal/greater/less cascade chain itself: it generates the cascade inputs for each slice and registers that slice's cascade outputs as the inputs for the next slice.
- Sits between operand producers and control logic that needs a compare result with a small area cost.

---
 rtl/seq_cmp_pkg.sv | 23 ++
 rtl/cmp_slice.sv | 29 ++
 rtl/seq_cascade_comparator.sv | 164 ++++++++++++++++
 tb/tb_seq_cascade_comparator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the sequential cascade comparator.
// Optional feature macro used by the top: SEQ_CMP_CASCADE_IN_EN.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_SLICE_W    = 3;
  localparam int DEF_NUM_SLICES = 4;

  function automatic int operand_width(input int slice_w, input int num_slices);
    return slice_w * num_slices;
  endfunction

  // A single-slice build still needs a 1-bit counter.
  function automatic int counter_width(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// One combinational slice of the equal/greater/less cascade chain.
module cmp_slice #(
  parameter int W = 3
) (
  input  logic [W-1:0] a_s,
  input  logic [W-1:0] b_s,
  input  logic         ce_in,
  input  logic         cg_in,
  input  logic         cl_in,
  output logic         ce_out,
  output logic         cg_out,
  output logic         cl_out
);

  logic slice_eq;
  logic slice_gt;
  logic slice_lt;

  // An equal slice passes the lower-order verdict through unchanged.
  always_comb begin
    slice_eq = (a_s == b_s);
    slice_gt = (a_s > b_s);
    slice_lt = (a_s < b_s);
    ce_out   = ce_in & slice_eq;
    cg_out   = slice_gt | (slice_eq & cg_in);
    cl_out   = slice_lt | (slice_eq & cl_in);
  end

endmodule

// File: rtl/seq_cascade_comparator.sv
// Multi-cycle unsigned magnitude comparator, one slice per clock, LSB slice first.
// Define SEQ_CMP_CASCADE_IN_EN to add the ie/ig/il cascade seed inputs.
module seq_cascade_comparator
  import seq_cmp_pkg::*;
#(
  parameter int SLICE_W    = DEF_SLICE_W,
  parameter int NUM_SLICES = DEF_NUM_SLICES
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [operand_width(SLICE_W, NUM_SLICES)-1:0] a,
  input  logic [operand_width(SLICE_W, NUM_SLICES)-1:0] b,
`ifdef SEQ_CMP_CASCADE_IN_EN
  input  logic                                          ie,
  input  logic                                          ig,
  input  logic                                          il,
`endif
  output logic                                          busy,
  output logic                                          done,
  output logic                                          eq,
  output logic                                          gt,
  output logic                                          lt
);

  localparam int OP_W  = operand_width(SLICE_W, NUM_SLICES);
  localparam int CNT_W = counter_width(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

  state_t state;
  state_t state_nxt;

  logic [OP_W-1:0]    a_q;
  logic [OP_W-1:0]    b_q;
  logic [CNT_W-1:0]   cnt;
  logic               ce;
  logic               cg;
  logic               cl;
  logic               ce_nxt;
  logic               cg_nxt;
  logic               cl_nxt;
  logic               seed_e;
  logic               seed_g;
  logic               seed_l;
  logic [SLICE_W-1:0] a_slices [NUM_SLICES];
  logic [SLICE_W-1:0] b_slices [NUM_SLICES];
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;

`ifdef SEQ_CMP_CASCADE_IN_EN
  always_comb begin
    seed_e = ie;
    seed_g = ig;
    seed_l = il;
  end
`else
  always_comb begin
    seed_e = 1'b1;
    seed_g = 1'b0;
    seed_l = 1'b0;
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_SLICES; i++) begin
      a_slices[i] = a_q[i*SLICE_W +: SLICE_W];
      b_slices[i] = b_q[i*SLICE_W +: SLICE_W];
    end
    a_sl = a_slices[cnt];
    b_sl = b_slices[cnt];
  end

  cmp_slice #(
    .W (SLICE_W)
  ) u_slice (
    .a_s    (a_sl),
    .b_s    (b_sl),
    .ce_in  (ce),
    .cg_in  (cg),
    .cl_in  (cl),
    .ce_out (ce_nxt),
    .cg_out (cg_nxt),
    .cl_out (cl_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Results only move on the edge that finishes the top slice, so they stay stable during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      ce  <= 1'b1;
      cg  <= 1'b0;
      cl  <= 1'b0;
      eq  <= 1'b0;
      gt  <= 1'b0;
      lt  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            ce  <= seed_e;
            cg  <= seed_g;
            cl  <= seed_l;
            cnt <= '0;
          end
        end
        RUN: begin
          ce <= ce_nxt;
          cg <= cg_nxt;
          cl <= cl_nxt;
          if (cnt == LAST) begin
            eq  <= ce_nxt;
            gt  <= cg_nxt;
            lt  <= cl_nxt;
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cascade_comparator.sv
// Scoreboard bench for seq_cascade_comparator; seed tests run when SEQ_CMP_CASCADE_IN_EN is defined.
module tb_seq_cascade_comparator;

  localparam int SW = 3;
  localparam int NS = 4;
  localparam int OW = SW * NS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [OW-1:0] a;
  logic [OW-1:0] b;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic          lt;
`ifdef SEQ_CMP_CASCADE_IN_EN
  logic          ie;
  logic          ig;
  logic          il;
`endif

  seq_cascade_comparator #(
    .SLICE_W    (SW),
    .NUM_SLICES (NS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SEQ_CMP_CASCADE_IN_EN
    .ie    (ie),
    .ig    (ig),
    .il    (il),
`endif
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] res;
    int         done_cyc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation, on the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output({e.name, "_result"}, {29'b0, eq, gt, lt}, {29'b0, e.res});
        check_output({e.name, "_latency"}, cyc, e.done_cyc);
      end
    end
  end

  // seed is {ie,ig,il}; exp_res is {eq,gt,lt}.
  task automatic apply_stimulus(input string name, input logic [OW-1:0] av, input logic [OW-1:0] bv,
                                input logic [2:0] seed, input logic [2:0] exp_res, input bit expect_done);
    exp_t e;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
`ifdef SEQ_CMP_CASCADE_IN_EN
    {ie, ig, il} = seed;
`endif
    if (expect_done) begin
      e.res      = exp_res;
      e.done_cyc = cyc + NS + 1;
      e.name     = $sformatf("%s(seed=%b)", name, seed);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = 12'($urandom());
    b     = 12'($urandom());
`ifdef SEQ_CMP_CASCADE_IN_EN
    {ie, ig, il} = 3'($urandom());
`endif
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check_output("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SEQ_CMP_CASCADE_IN_EN
    {ie, ig, il} = 3'b100;
`endif
    #12;
    check_output("reset_outs", {27'b0, busy, done, eq, gt, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal operands, with busy/done timing checked cycle by cycle.
    apply_stimulus("eq_5a3", 12'h5A3, 12'h5A3, 3'b100, 3'b100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("busy_c%0d", i + 1), {31'b0, busy}, 32'd1);
      if (i < 4) check_output($sformatf("done_early_c%0d", i + 1), {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    check_output("busy_idle", {31'b0, busy}, 32'd0);
    wait_drain();

    apply_stimulus("gt_401", 12'h401, 12'h3FF, 3'b100, 3'b010, 1'b1);
    wait_drain();
    apply_stimulus("lt_001", 12'h001, 12'h002, 3'b100, 3'b001, 1'b1);
    wait_drain();
    apply_stimulus("gt_fff", 12'hFFF, 12'h000, 3'b100, 3'b010, 1'b1);
    wait_drain();
    apply_stimulus("lt_000", 12'h000, 12'hFFF, 3'b100, 3'b001, 1'b1);
    wait_drain();
    apply_stimulus("lt_7ff", 12'h7FF, 12'h800, 3'b100, 3'b001, 1'b1);
    wait_drain();
    apply_stimulus("eq_000", 12'h000, 12'h000, 3'b100, 3'b100, 1'b1);
    wait_drain();
    apply_stimulus("gt_800", 12'h800, 12'h7FF, 3'b100, 3'b010, 1'b1);
    wait_drain();

    // Restart attempts during RUN and DONE must be ignored; previous gt result holds during RUN.
    apply_stimulus("busy_ign", 12'h123, 12'h456, 3'b100, 3'b001, 1'b1);
    for (int j = 1; j <= 5; j++) begin
      start = 1'b1;
      a     = 12'hFFF;
      b     = 12'h000;
      if (j == 3) check_output("hold_during_run", {29'b0, eq, gt, lt}, 32'b010);
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);

    // Reset in the second RUN cycle aborts without a done pulse.
    apply_stimulus("abort", 12'h0AA, 12'h055, 3'b100, 3'b010, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("abort_outs", {27'b0, busy, done, eq, gt, lt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    apply_stimulus("after_abort", 12'h0AA, 12'h055, 3'b100, 3'b010, 1'b1);
    wait_drain();

`ifdef SEQ_CMP_CASCADE_IN_EN
    apply_stimulus("seed_gt", 12'h0F0, 12'h0F0, 3'b010, 3'b010, 1'b1);
    wait_drain();
    apply_stimulus("seed_none", 12'h0F0, 12'h0F0, 3'b000, 3'b000, 1'b1);
    wait_drain();
    apply_stimulus("seed_lt", 12'h0F0, 12'h0F0, 3'b001, 3'b001, 1'b1);
    wait_drain();
    apply_stimulus("seed_override", 12'h001, 12'h002, 3'b010, 3'b001, 1'b1);
    wait_drain();
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
